// File: rtl/inv_key_expand_pkg.sv
// Shared AES-128 key schedule constants: round count, FSM encoding, Rcon table.
// Latency: none; declarations and a pure combinational lookup only.
// Backpressure: not applicable.
package inv_key_expand_pkg;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } state_t;

  // Round constant for round i (1..10); round 0 never uses one.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_key_expand_if.sv
// Request/round-key bus between a key consumer and the inverse key expander.
// Latency: none; wiring only.
// Backpressure: none; the expander streams one round key per cycle unconditionally.
interface inv_key_expand_if;
  logic         start;
  logic [127:0] KEY;
  logic         busy;
  logic         valid;
  logic         last;
  logic [3:0]   RND;
  logic [127:0] EXKEY;

  modport master (output start, KEY, input busy, valid, last, RND, EXKEY);
  modport slave  (input start, KEY, output busy, valid, last, RND, EXKEY);
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Latency: purely combinational.
// Backpressure: not applicable.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0 as AES requires), by square-and-multiply.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform with constant 0x63.
  always_comb begin
    inv = ginv(x);
    y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/inv_key_expand.sv
// Inverse AES-128 key expander: streams round keys 10 down to 0 from the round-10 key.
// Latency: first beat the cycle after start, then one round key per cycle for 11 beats.
// Backpressure: none; start is ignored while busy and the stream cannot be stalled.
module inv_key_expand
  import inv_key_expand_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  inv_key_expand_if.slave bus
);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  b3, rot, sub;
  logic [127:0] prev_key;

  assign a0  = key_q[127:96];
  assign a1  = key_q[95:64];
  assign a2  = key_q[63:32];
  assign a3  = key_q[31:0];
  assign b3  = a3 ^ a2;
  assign rot = {b3[23:0], b3[31:24]};

  // SubWord: one S-box per byte of the rotated word.
  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .x (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign prev_key = {a0 ^ sub ^ {rcon(rnd_q), 24'h0}, a1 ^ a0, a2 ^ a1, b3};

  // State, key and round registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next state: capture on start in IDLE, step back one round per cycle in OUT.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.KEY;
          rnd_d   = NUM_ROUNDS;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (rnd_q != 4'd0) begin
          key_d = prev_key;
          rnd_d = rnd_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the registers directly; key and round hold while idle.
  always_comb begin
    bus.valid = (state_q == ST_OUT);
    bus.busy  = (state_q == ST_OUT);
    bus.last  = (state_q == ST_OUT) && (rnd_q == 4'd0);
    bus.RND   = rnd_q;
    bus.EXKEY = key_q;
  end

endmodule

// File: tb/tb_inv_key_expand.sv
module tb_inv_key_expand;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_key_expand_if bus ();

  inv_key_expand dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] rcon_t [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct packed {
    logic         last;
    logic [3:0]   rnd;
    logic [127:0] key;
  } beat_t;

  beat_t        q[$];
  logic         exp_valid;
  logic         exp_last;
  logic [3:0]   exp_rnd;
  logic [127:0] exp_key;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One step of the inverse schedule, straight from the round-key equations.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input int i);
    logic [31:0] w0, w1, w2, w3, t, n0;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = w3 ^ w2;
    t  = {t[23:0], t[31:24]};
    n0 = w0 ^ {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
            ^ {rcon_t[i], 24'h0};
    return {n0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: builds S-box by generator walk, then tracks expected outputs per edge.
  initial begin : model
    logic [7:0]   p, g, x;
    logic         s_rst, s_start;
    logic [127:0] s_key, k;
    beat_t        b;
    p = 8'h01;
    g = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      g = g ^ {g[6:0], 1'b0};
      g = g ^ {g[5:0], 2'b0};
      g = g ^ {g[3:0], 4'b0};
      if (g[7]) g = g ^ 8'h09;
      x = g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    exp_rnd   = 4'd0;
    exp_key   = '0;
    forever begin
      @(posedge clk);
      s_rst   = reset;
      s_start = bus.start;
      s_key   = bus.KEY;
      if (s_rst) begin
        q.delete();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_rnd   = 4'd0;
        exp_key   = '0;
      end else if (exp_valid) begin
        if (q.size() > 0) begin
          b = q.pop_front();
          exp_last = b.last;
          exp_rnd  = b.rnd;
          exp_key  = b.key;
        end else begin
          exp_valid = 1'b0;
          exp_last  = 1'b0;
        end
      end else if (s_start) begin
        k = s_key;
        for (int r = 10; r >= 0; r--) begin
          q.push_back('{r == 0, 4'(r), k});
          if (r > 0) k = prev_key(k, r);
        end
        b = q.pop_front();
        exp_valid = 1'b1;
        exp_last  = b.last;
        exp_rnd   = b.rnd;
        exp_key   = b.key;
      end
      @(negedge clk);
      chk("cyc_valid", 128'(bus.valid), 128'(exp_valid));
      chk("cyc_busy",  128'(bus.busy),  128'(exp_valid));
      chk("cyc_last",  128'(bus.last),  128'(exp_last));
      chk("cyc_rnd",   128'(bus.RND),   128'(exp_rnd));
      chk("cyc_exkey", bus.EXKEY, exp_key);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    bus.start = 1'b1;
    bus.KEY   = k;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_rnd(input logic [3:0] n);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.valid && bus.RND == n) found = 1'b1;
      else tick();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_rnd actual=timeout required=RND %0d", n);
    end
  endtask

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // Directed scenarios followed by randomized traffic.
  initial begin : stim
    int   n;
    logic v [40];
    int   run, zrun;
    bit   seen_one;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.KEY   = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 128'(bus.valid), 128'd0);
    chk("rst_busy",  128'(bus.busy),  128'd0);
    chk("rst_rnd",   128'(bus.RND),   128'd0);
    chk("rst_exkey", bus.EXKEY, 128'd0);

    // Known-answer run.
    tick();
    pulse_start(K10);
    chk("kat_r10_rnd", 128'(bus.RND), 128'd10);
    chk("kat_r10_key", bus.EXKEY, K10);
    tick();
    chk("kat_r9_rnd", 128'(bus.RND), 128'd9);
    chk("kat_r9_key", bus.EXKEY, 128'hac7766f319fadc2128d12941575c006e);
    tick();
    chk("kat_r8_key", bus.EXKEY, 128'head27321b58dbad2312bf5607f8d292f);
    repeat (7) tick();
    chk("kat_r1_rnd", 128'(bus.RND), 128'd1);
    chk("kat_r1_key", bus.EXKEY, 128'ha0fafe1788542cb123a339392a6c7605);
    tick();
    chk("kat_r0_key",  bus.EXKEY, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("kat_r0_last", 128'(bus.last), 128'd1);
    tick();
    chk("kat_end_valid", 128'(bus.valid), 128'd0);
    chk("kat_end_busy",  128'(bus.busy),  128'd0);

    // Start during a run is ignored.
    tick();
    pulse_start(rnd128());
    wait_rnd(4'd5);
    pulse_start(rnd128());
    repeat (10) tick();
    chk("ign_idle", 128'(bus.valid), 128'd0);

    // Reset mid-run, then a full run.
    pulse_start(rnd128());
    wait_rnd(4'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 128'(bus.valid), 128'd0);
    chk("mid_rst_busy",  128'(bus.busy),  128'd0);
    chk("mid_rst_rnd",   128'(bus.RND),   128'd0);
    chk("mid_rst_exkey", bus.EXKEY, 128'd0);
    tick();
    pulse_start(rnd128());
    n = 0;
    repeat (14) begin
      if (bus.valid) n++;
      tick();
    end
    chk("full_run_beats", 128'(n), 128'd11);

    // Reset and start together from IDLE.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.KEY   = rnd128();
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) begin
      chk("rst_start_valid", 128'(bus.valid), 128'd0);
      tick();
    end

    // Start held high: 11 beats, one idle cycle, repeat.
    bus.start = 1'b1;
    bus.KEY   = rnd128();
    tick();
    for (int i = 0; i < 40; i++) begin
      v[i] = bus.valid;
      tick();
    end
    bus.start = 1'b0;
    run = 0;
    zrun = 0;
    seen_one = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (v[i]) begin
        if (zrun > 0 && seen_one) chk("hold_gap", 128'(zrun), 128'd1);
        zrun = 0;
        run++;
        seen_one = 1'b1;
      end else begin
        if (run > 0) chk("hold_run", 128'(run), 128'd11);
        run = 0;
        zrun++;
      end
    end
    repeat (14) tick();

    // Randomized traffic with stray starts and resets.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      pulse_start(rnd128());
      repeat (13) begin
        case ($urandom_range(0, 19))
          0: reset = 1'b1;
          1: begin bus.start = 1'b1; bus.KEY = rnd128(); end
          default: ;
        endcase
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
      end
    end
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_key_expand.md
INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin a run; honoured only in IDLE.
REQ-004 SHALL have port KEY, input, 128 bits: AES-128 round-10 key, word w40 in bits [127:96]; sampled on the cycle start is honoured.
REQ-005 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-006 SHALL have port valid, output, 1 bit: EXKEY and RND hold a round key this cycle.
REQ-007 SHALL have port last, output, 1 bit: high with the final valid beat (round 0).
REQ-008 SHALL have port RND, output, 4 bits: round index of EXKEY (10 down to 0).
REQ-009 SHALL have port EXKEY, output, 128 bits: round key for round RND, same word order as KEY.

Function
REQ-010 SHALL implement two states: IDLE and OUT.
REQ-011 In IDLE, start=1 SHALL load KEY into the key register, set RND=10 and enter OUT on the next edge.
REQ-012 In OUT, the block SHALL drive valid=1, busy=1, and EXKEY=key register every cycle.
REQ-013 In OUT with RND>0, the next edge SHALL replace the key register with the previous round key and decrement RND.
REQ-014 In OUT with RND=0, the block SHALL drive last=1, and the next edge SHALL return it to IDLE.
REQ-015 A run SHALL produce exactly 11 consecutive valid beats: RND 10,9,...,0, first beat on the cycle after start, with no gaps.
REQ-016 Previous round key: given current words a0..a3 at round i, the block SHALL compute
- b3=a3^a2, b2=a2^a1, b1=a1^a0;
- b0=a0^SubWord(RotWord(b3))^{Rcon[i],24'h0}.
REQ-017 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-018 RotWord SHALL rotate a word left by one byte; SubWord SHALL apply the AES S-box to each byte.
REQ-019 The round-key update SHALL be purely registered at one round per clock, with no multicycle paths.
REQ-020 start SHALL be ignored while busy=1; the current run SHALL continue unaffected.
REQ-021 start held high SHALL begin a new run only from IDLE, so back-to-back runs have at least one idle cycle between them.
REQ-022 In IDLE, valid, last and busy SHALL be 0; EXKEY and RND SHALL hold their last driven values.

Reset
REQ-023 reset=1 SHALL force IDLE, valid=0, last=0, busy=0, RND=0 and EXKEY=0 on the next edge, regardless of state.
REQ-024 reset SHALL take priority over start in the same cycle.
REQ-025 After reset releases mid-run, no further valid beats SHALL occur until a new start.

Structure
REQ-026 The Rcon table, the state encodings and the round-count constant (10) SHALL live in a shared include/package used by both the forward and inverse key blocks.
REQ-027 The S-box SHALL be a separate combinational sub-module, aes_sbox (8-bit in, 8-bit out), instantiated four times for SubWord.

Verification
REQ-028 Start with KEY=d014f9a8c9ee2589e13f0cc8b6630ca6 -> beats 1..3 give:
- RND=10, EXKEY=KEY;
- RND=9, EXKEY=ac7766f319fadc2128d12941575c006e;
- RND=8, EXKEY=ead27321b58dbad2312bf5607f8d292f.
REQ-029 Same run -> RND=1 beat gives EXKEY=a0fafe1788542cb123a339392a6c7605; RND=0 beat gives EXKEY=2b7e151628aed2a6abf7158809cf4f3c with last=1; the next cycle has valid=0 and busy=0.
REQ-030 Pulse start again during beat RND=5 with a different KEY -> the run completes unchanged; the later KEY is not captured.
REQ-031 Assert reset for one cycle during beat RND=6 -> the next cycle has valid=0, busy=0, RND=0 and EXKEY=0; a new start then yields a full 11-beat run.
REQ-032 Assert start and reset in the same cycle from IDLE -> the block stays in IDLE and no valid beat follows.
REQ-033 Hold start=1 continuously -> runs of 11 valid beats separated by exactly one idle cycle.
